// File: rtl/srl_fifo.sv
// ---------------------------------------------------------------------------
// srl_fifo
//   First-word-fall-through FIFO whose storage is a plain shift register with
//   no reset, so synthesis can map it onto SRL primitives. New words always
//   enter at entry 0, and the oldest word sits at entry count-1. A read
//   therefore only decrements the occupancy and never moves data.
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset (wins over wr_en / rd_en)
//   wr_en        : write request
//   wr_data      : write word (C_DATA_WIDTH bits)
//   rd_en        : read (pop) request
//   rd_data      : oldest stored word, valid whenever empty = 0
//   empty        : occupancy == 0                       (registered)
//   full         : occupancy == C_DEPTH                 (registered)
//   almost_full  : occupancy >= C_AFULL_THRESH          (registered)
//   count        : current occupancy, $clog2(C_DEPTH)+1 bits (registered)
//   overflow     : one-cycle pulse after a write rejected because full
//   underflow    : one-cycle pulse after a read rejected because empty
//
// Handshake: a write is accepted on a rising edge where wr_en = 1 and
// full = 0; a read is accepted on a rising edge where rd_en = 1 and
// empty = 0. Both flags are registered, so acceptance never depends
// combinationally on the request inputs of the same cycle. Requests made
// against the opposing flag are dropped and reported by overflow/underflow
// in the following cycle.
// ---------------------------------------------------------------------------
module srl_fifo #(
    parameter int C_DATA_WIDTH   = 16,
    parameter int C_DEPTH        = 16,
    parameter int C_AFULL_THRESH = C_DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [C_DATA_WIDTH-1:0]    wr_data,
    input  logic                       rd_en,
    output logic [C_DATA_WIDTH-1:0]    rd_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(C_DEPTH):0]   count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(C_DEPTH);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(C_DEPTH);
    localparam logic [AW:0]   AFULL_C = (AW+1)'(C_AFULL_THRESH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_IDX = AW'(1);

    // Storage: deliberately no reset so it stays SRL-mappable.
    logic [C_DATA_WIDTH-1:0] mem_q [C_DEPTH];

    logic [AW:0]   count_q, count_d;
    logic          empty_q, full_q, afull_q;
    logic          overflow_q, underflow_q;
    logic          wr_ok, rd_ok;
    logic [AW-1:0] rd_idx;

    // Acceptance uses only registered flags; reset suppresses both.
    always_comb begin
        wr_ok   = wr_en & ~full_q  & ~rst;
        rd_ok   = rd_en & ~empty_q & ~rst;
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + ONE_C;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - ONE_C;
        end
    end

    // Shift only on an accepted write; a read never disturbs storage.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[0] <= wr_data;
            for (int i = 1; i < C_DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DEPTH_C);
            afull_q     <= (count_d >= AFULL_C);
            overflow_q  <= wr_en & full_q;
            underflow_q <= rd_en & empty_q;
        end
    end

    // Oldest word lives at count-1. At count == C_DEPTH the low AW bits are
    // zero, so the subtraction wraps to C_DEPTH-1, which is the right entry.
    // At count == 0 the index is meaningless, which is fine because rd_data
    // is don't-care while empty.
    assign rd_idx  = count_q[AW-1:0] - ONE_IDX;
    assign rd_data = mem_q[rd_idx];

    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_srl_fifo.sv
// ---------------------------------------------------------------------------
// tb_srl_fifo
//   Self-checking bench for srl_fifo (C_DATA_WIDTH = 16, C_DEPTH = 16).
//   Every cycle is driven through one step task; a queue-based reference
//   model predicts data order, occupancy and flags.
// ---------------------------------------------------------------------------
module tb_srl_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data;
    logic          empty, full, almost_full;
    logic [4:0]    count;
    logic          overflow, underflow;

    always #5 clk = ~clk;

    srl_fifo #(
        .C_DATA_WIDTH   (W),
        .C_DEPTH        (DEPTH),
        .C_AFULL_THRESH (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_ovf = 1'b0;
    logic         exp_unf = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive on the falling edge, compare the popped word
    // before the rising edge, update the model at the edge, then check the
    // registered outputs shortly after it.
    task automatic step(input logic r, input logic we, input logic [W-1:0] wd, input logic re);
        int cnt;
        @(negedge clk);
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        cnt     = exp_q.size();
        if (!r && re && cnt > 0) begin
            check("rd_data", 32'(rd_data), 32'(exp_q[0]));
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = we && (cnt == DEPTH);
            exp_unf = re && (cnt == 0);
            if (re && cnt > 0) void'(exp_q.pop_front());
            if (we && cnt < DEPTH) exp_q.push_back(wd);
        end
        #1;
        cnt = exp_q.size();
        check("count",       32'(count),       32'(cnt));
        check("empty",       32'(empty),       32'(cnt == 0));
        check("full",        32'(full),        32'(cnt == DEPTH));
        check("almost_full", 32'(almost_full), 32'(cnt >= AFULL));
        check("overflow",    32'(overflow),    32'(exp_ovf));
        check("underflow",   32'(underflow),   32'(exp_unf));
        if (cnt > 0) begin
            check("rd_data_x", 32'($isunknown(rd_data)), 32'(0));
        end
    endtask

    task automatic random_run(input int cycles, input int wr_pct, input int rd_pct);
        for (int i = 0; i < cycles; i++) begin
            step(1'b0,
                 ($urandom_range(0, 99) < wr_pct),
                 W'($urandom_range(0, 16'hFFFF)),
                 ($urandom_range(0, 99) < rd_pct));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset, including requests that must be ignored.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 16'h7777, 1'b1);

        // Fill 0x0001..0x0010, then overflow with 0xDEAD.
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, W'(i), 1'b0);
        step(1'b0, 1'b1, 16'hDEAD, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Drain; scoreboard proves 0x0001..0x0010 order and no 0xDEAD.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Underflow with concurrent write: no bypass, word visible next cycle.
        step(1'b0, 1'b1, 16'h00AA, 1'b1);
        check("uf_wr_data", 32'(rd_data), 32'h00AA);
        step(1'b0, 1'b0, '0, 1'b1);

        // Full with concurrent read: write dropped, read completes.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, W'(16'h0100 + i), 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Simultaneous read/write at count = 5 for 20 cycles.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'(16'h0200 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, W'(16'h0300 + i), 1'b1);

        // Reset mid-stream at count = 9 together with a write.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'(16'h0400 + i), 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        check("post_rst_data", 32'(rd_data), 32'h1234);
        step(1'b0, 1'b0, '0, 1'b1);

        // Random traffic: balanced, write-heavy, read-heavy.
        random_run(4000, 50, 50);
        random_run(3000, 80, 20);
        random_run(3000, 20, 80);

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
